dco_code_slewer: RTL and testbench
==================================

DCO_CODE_SLEWER -- requirements
Module: dco_code_slewer

Interface
REQ-001 SHALL have parameter N_COARSE, default 128: number of thermometer coarse cells driven.
REQ-002 SHALL have parameter CODE_W, default $clog2(N_COARSE+1): width of binary code (count of enabled cells).
REQ-003 SHALL have parameter MIN_CODE, default 1: lowest legal code, so at least one cell is always enabled.
REQ-004 SHALL have parameter MAX_STEP, default 4: largest code change per clock while slewing.
REQ-005 SHALL have parameter FRAC_W, default 4: fractional-code width for dither.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port code_valid, input, 1: a new target is offered.
REQ-009 SHALL have port code_ready, output, 1: a target can be accepted.
REQ-010 SHALL have port code_in, input, CODE_W: target integer code.
REQ-011 SHALL have port frac_in, input, FRAC_W: target fractional code, sampled with code_in.
REQ-012 SHALL have port hold, input, 1: freeze the current code while asserted.
REQ-013 SHALL have port coarse_out, output, N_COARSE: thermometer code, with bit i = 1 iff i < out_code.
REQ-014 SHALL have port cur_code, output, CODE_W: integer code currently applied, before dither.
REQ-015 SHALL have port settled, output, 1: cur_code equals the target.
REQ-016 SHALL have port clamp_err, output, 1: one-cycle pulse when an accepted target was clamped.

Function
REQ-017 SHALL accept a target on a cycle where code_valid and code_ready are both 1.
REQ-018 SHALL drive code_ready = 1 in the IDLE and LOCK states only, and 0 in SLEW.
REQ-019 SHALL clamp an accepted code_in to the range [MIN_CODE, N_COARSE].
REQ-020 SHALL pulse clamp_err on the cycle after acceptance when the clamp changed the value.
REQ-021 SHALL use a state machine with states IDLE, SLEW and LOCK, and the following transitions:
  - IDLE -> SLEW on accept when target != cur_code.
  - IDLE -> LOCK on accept when target == cur_code.
  - SLEW -> LOCK when cur_code reaches target.
  - LOCK -> SLEW on accept when target != cur_code.
  - LOCK -> LOCK on accept when target == cur_code.
REQ-022 SHALL, in SLEW, move cur_code toward target by min(MAX_STEP, |target-cur_code|) each cycle, so it never overshoots.
REQ-023 SHALL, while hold is 1, leave cur_code, the dither accumulator and the state unchanged.
REQ-024 SHALL NOT accept a target while hold is 1; code_ready remains as given by REQ-018.
REQ-025 SHALL assert settled = 1 only in the LOCK state.
REQ-026 SHALL register coarse_out, giving 1-cycle latency from cur_code/out_code to coarse_out.
REQ-027 SHALL, when code_valid is 1 in the same cycle as the final SLEW step, refuse the new target (ready = 0); it is accepted the following cycle in LOCK.
REQ-028 SHALL compute all code arithmetic at CODE_W+1 bits so that no result wraps.

Reset
REQ-029 SHALL, on reset, set state = IDLE, cur_code = MIN_CODE, target = MIN_CODE and the dither accumulator = 0.
REQ-030 SHALL, on reset, drive coarse_out with only bit 0 set, settled = 0, clamp_err = 0 and code_ready = 1.
REQ-031 SHALL let reset win over every other input, including during SLEW, and discard any target in flight.

Configuration
REQ-032 SHALL, when DCO_CODE_DITHER_EN is defined, run a first-order sigma-delta accumulator on frac_in in LOCK:
  - Each cycle: acc = acc + frac; carry = acc overflow.
  - out_code = min(cur_code + carry, N_COARSE).
  - The accumulator is cleared on entry to SLEW.
REQ-033 SHALL, when DCO_CODE_DITHER_EN is not defined, ignore frac_in, remove the accumulator and set out_code = cur_code.

Structure
REQ-034 SHALL place the state enum (IDLE, SLEW, LOCK) and the code-clamp/step helper functions in package dco_code_pkg.
REQ-035 SHALL implement the binary-to-thermometer decode as sub-module dco_therm_enc, parametrised by N_COARSE and CODE_W.

Verification
REQ-036 SHALL cover reset: after reset, coarse_out = 128'h1, cur_code = 1, settled = 0 and code_ready = 1.
REQ-037 SHALL cover slew: accept code_in = 10 from 1 -> cur_code goes 5, 9, 10 on successive cycles, then settled = 1 one cycle later.
REQ-038 SHALL cover clamping: code_in = 0 -> target 1 with clamp_err pulse; code_in = 200 -> target 128 with clamp_err pulse, and coarse_out ends all-ones.
REQ-039 SHALL cover hold: assert hold for 3 cycles mid-slew from 1 to 20 -> cur_code is frozen for 3 cycles, then resumes in +4 steps.
REQ-040 SHALL cover dither with DCO_CODE_DITHER_EN defined: lock at 50 with frac_in = 4 (FRAC_W = 4) -> out_code = 51 on exactly 4 of every 16 cycles.
REQ-041 SHALL cover reset mid-operation: assert reset during a slew from 1 to 100 -> the next cycle is IDLE with cur_code = 1, and the abandoned target is never reached.

Source files
------------

// File: rtl/dco_code_pkg.sv
// Shared types and code arithmetic helpers for the DCO code slewer.
// Helpers work in int, wider than CODE_W+1, so clamp and step results never wrap.
package dco_code_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLEW = 2'd1,
    LOCK = 2'd2
  } slew_state_e;

  function automatic int clamp_code(input int code, input int lo, input int hi);
    if (code < lo) return lo;
    if (code > hi) return hi;
    return code;
  endfunction

  // Moves cur toward tgt by at most max_step and never overshoots.
  function automatic int step_toward(input int cur, input int tgt, input int max_step);
    if (tgt > cur) return (tgt - cur > max_step) ? cur + max_step : tgt;
    if (tgt < cur) return (cur - tgt > max_step) ? cur - max_step : tgt;
    return cur;
  endfunction

endpackage

// File: rtl/dco_therm_enc.sv
// Binary code to thermometer decode: bit i is set iff i < code.
module dco_therm_enc #(
  parameter int N_COARSE = 128,
  parameter int CODE_W   = $clog2(N_COARSE + 1)
) (
  input  logic [CODE_W-1:0]   code,
  output logic [N_COARSE-1:0] therm
);

  always_comb begin
    therm = '0;
    for (int i = 0; i < N_COARSE; i++) therm[i] = (i < int'(code));
  end

endmodule

// File: rtl/dco_code_slewer.sv
// Rate-limited DCO coarse-code slewer with registered thermometer output.
// Optional sigma-delta dither on the fractional code when DCO_CODE_DITHER_EN is defined.
//
// state | meaning
// IDLE  | out of reset, no target accepted yet, ready for a target
// SLEW  | stepping cur_code toward target, targets refused
// LOCK  | cur_code equals target, ready for a new target
module dco_code_slewer
  import dco_code_pkg::*;
#(
  parameter int N_COARSE = 128,
  parameter int CODE_W   = $clog2(N_COARSE + 1),
  parameter int MIN_CODE = 1,
  parameter int MAX_STEP = 4,
  parameter int FRAC_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  output logic                code_ready,
  input  logic [CODE_W-1:0]   code_in,
  input  logic [FRAC_W-1:0]   frac_in,
  input  logic                hold,
  output logic [N_COARSE-1:0] coarse_out,
  output logic [CODE_W-1:0]   cur_code,
  output logic                settled,
  output logic                clamp_err
);

  slew_state_e state_q, state_d;
  logic [CODE_W-1:0]   cur_q, tgt_q, out_code;
  logic [N_COARSE-1:0] therm_d, coarse_q;
  logic                clamp_err_q, accept;
  int                  tgt_new, step_next;

  assign code_ready = (state_q != SLEW);
  assign accept     = code_valid && code_ready && !hold;
  assign tgt_new    = clamp_code(int'(code_in), MIN_CODE, N_COARSE);
  assign step_next  = step_toward(int'(cur_q), int'(tgt_q), MAX_STEP);

  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        IDLE, LOCK: if (accept) state_d = (tgt_new == int'(cur_q)) ? LOCK : SLEW;
        SLEW:       if (cur_q == tgt_q) state_d = LOCK;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= CODE_W'(MIN_CODE);
      tgt_q       <= CODE_W'(MIN_CODE);
      clamp_err_q <= 1'b0;
      for (int i = 0; i < N_COARSE; i++) coarse_q[i] <= (i < MIN_CODE);
    end else begin
      state_q     <= state_d;
      clamp_err_q <= accept && (tgt_new != int'(code_in));
      if (accept) tgt_q <= CODE_W'(tgt_new);
      if (!hold && state_q == SLEW) cur_q <= CODE_W'(step_next);
      coarse_q    <= therm_d;
    end
  end

`ifdef DCO_CODE_DITHER_EN
  logic [FRAC_W-1:0] frac_q, acc_q;
  logic [FRAC_W:0]   acc_sum;
  logic              carry;

  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_q};
  assign carry    = (state_q == LOCK) && !hold && acc_sum[FRAC_W];
  assign out_code = (int'(cur_q) + int'(carry) > N_COARSE) ? CODE_W'(N_COARSE)
                                                          : cur_q + CODE_W'(carry);

  always_ff @(posedge clk) begin
    if (reset) begin
      frac_q <= '0;
      acc_q  <= '0;
    end else begin
      if (accept) frac_q <= frac_in;
      // Restart the modulator from zero on every new slew.
      if (!hold) begin
        if (state_q != SLEW && state_d == SLEW) acc_q <= '0;
        else if (state_q == LOCK)               acc_q <= acc_sum[FRAC_W-1:0];
      end
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^frac_in;
  assign out_code    = cur_q;
`endif

  dco_therm_enc #(.N_COARSE(N_COARSE), .CODE_W(CODE_W)) u_therm (
    .code  (out_code),
    .therm (therm_d)
  );

  assign coarse_out = coarse_q;
  assign cur_code   = cur_q;
  assign settled    = (state_q == LOCK);
  assign clamp_err  = clamp_err_q;

endmodule

// File: tb/tb_dco_code_slewer.sv
// Self-checking bench for dco_code_slewer with a behavioural slew model.
module tb_dco_code_slewer;

  localparam int N  = 128;
  localparam int CW = 8;
  localparam int PH_IDLE = 0, PH_MOVE = 1, PH_LOCK = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0, code_valid = 1'b0, hold = 1'b0;
  logic [CW-1:0] code_in = '0;
  logic [3:0]    frac_in = '0;
  logic          code_ready, settled, clamp_err;
  logic [N-1:0]  coarse_out;
  logic [CW-1:0] cur_code;

  int n_pass = 0, n_total = 0;

  int           m_cur, m_tgt, m_phase;
  bit           m_clamp;
  logic [N-1:0] m_coarse;

  always #5 clk = ~clk;

  dco_code_slewer dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_in    (code_in),
    .frac_in    (frac_in),
    .hold       (hold),
    .coarse_out (coarse_out),
    .cur_code   (cur_code),
    .settled    (settled),
    .clamp_err  (clamp_err)
  );

  function automatic logic [N-1:0] therm_of(input int m);
    logic [N:0] t;
    t = (129'(1) << m) - 129'(1);
    return t[N-1:0];
  endfunction

  task automatic model_step(input bit v, input int code, input bit h, input bit r);
    int c, d;
    m_clamp = 1'b0;
    if (r) begin
      m_cur = 1; m_tgt = 1; m_phase = PH_IDLE; m_coarse = therm_of(1);
    end else begin
      m_coarse = therm_of(m_cur);
      if (!h) begin
        if (m_phase == PH_MOVE) begin
          d = m_tgt - m_cur;
          if (d == 0) m_phase = PH_LOCK;
          else if (d > 0) m_cur += (d > 4) ? 4 : d;
          else m_cur -= (-d > 4) ? 4 : -d;
        end else if (v) begin
          c = (code < 1) ? 1 : ((code > N) ? N : code);
          m_clamp = (c != code);
          m_tgt = c;
          m_phase = (c == m_cur) ? PH_LOCK : PH_MOVE;
        end
      end
    end
  endtask

  task automatic drive_cycle(input bit v, input int code, input bit h, input bit r);
    code_valid = v; code_in = code[CW-1:0]; hold = h; reset = r;
    model_step(v, code, h, r);
    @(posedge clk); #1;
    code_valid = 1'b0; hold = 1'b0; reset = 1'b0;
  endtask

  task automatic wait_settled(input int budget);
    for (int k = 0; k < budget && settled !== 1'b1; k++) drive_cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive_cycle(0, 0, 0, 1);
    drive_cycle(1, 77, 0, 1);
    n_total++; if (coarse_out !== 128'h1) $display("FAIL reset_coarse got %h expected %h", coarse_out, 128'h1); else n_pass++;
    n_total++; if (cur_code !== 8'd1) $display("FAIL reset_cur got %0d expected 1", cur_code); else n_pass++;
    n_total++; if (settled !== 1'b0) $display("FAIL reset_settled got %b expected 0", settled); else n_pass++;
    n_total++; if (code_ready !== 1'b1) $display("FAIL reset_ready got %b expected 1", code_ready); else n_pass++;
    n_total++; if (clamp_err !== 1'b0) $display("FAIL reset_clamp_err got %b expected 0", clamp_err); else n_pass++;
  endtask

  task automatic test_slew();
    int exp_seq[3] = '{5, 9, 10};
    drive_cycle(0, 0, 0, 1);
    drive_cycle(1, 10, 0, 0);
    n_total++; if (cur_code !== 8'd1 || code_ready !== 1'b0)
      $display("FAIL slew_accept got cur %0d ready %b expected cur 1 ready 0", cur_code, code_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 0);
      n_total++; if (cur_code !== CW'(exp_seq[i]) || settled !== 1'b0)
        $display("FAIL slew_step%0d got cur %0d settled %b expected cur %0d settled 0", i, cur_code, settled, exp_seq[i]); else n_pass++;
    end
    drive_cycle(0, 0, 0, 0);
    n_total++; if (settled !== 1'b1 || code_ready !== 1'b1)
      $display("FAIL slew_lock got settled %b ready %b expected 1 1", settled, code_ready); else n_pass++;
    n_total++; if (coarse_out !== therm_of(10)) $display("FAIL slew_coarse got %h expected %h", coarse_out, therm_of(10)); else n_pass++;
  endtask

  task automatic test_clamp();
    drive_cycle(1, 0, 0, 0);
    n_total++; if (clamp_err !== 1'b1) $display("FAIL clamp_low_pulse got %b expected 1", clamp_err); else n_pass++;
    drive_cycle(0, 0, 0, 0);
    n_total++; if (clamp_err !== 1'b0) $display("FAIL clamp_low_pulse_end got %b expected 0", clamp_err); else n_pass++;
    wait_settled(60);
    n_total++; if (settled !== 1'b1 || cur_code !== 8'd1)
      $display("FAIL clamp_low_final got cur %0d settled %b expected cur 1 settled 1", cur_code, settled); else n_pass++;
    drive_cycle(1, 200, 0, 0);
    n_total++; if (clamp_err !== 1'b1) $display("FAIL clamp_high_pulse got %b expected 1", clamp_err); else n_pass++;
    wait_settled(60);
    n_total++; if (settled !== 1'b1 || cur_code !== 8'd128)
      $display("FAIL clamp_high_final got cur %0d settled %b expected cur 128 settled 1", cur_code, settled); else n_pass++;
    drive_cycle(0, 0, 0, 0);
    n_total++; if (coarse_out !== {N{1'b1}}) $display("FAIL clamp_high_coarse got %h expected all ones", coarse_out); else n_pass++;
    drive_cycle(1, 128, 0, 0);
    n_total++; if (clamp_err !== 1'b0 || settled !== 1'b1)
      $display("FAIL clamp_edge_128 got clamp_err %b settled %b expected 0 1", clamp_err, settled); else n_pass++;
  endtask

  task automatic test_hold();
    int exp_seq[3] = '{13, 17, 20};
    drive_cycle(0, 0, 0, 1);
    drive_cycle(1, 20, 0, 0);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    n_total++; if (cur_code !== 8'd9) $display("FAIL hold_pre got %0d expected 9", cur_code); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 50, 1, 0);
      n_total++; if (cur_code !== 8'd9 || settled !== 1'b0)
        $display("FAIL hold_frozen%0d got cur %0d settled %b expected cur 9 settled 0", i, cur_code, settled); else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 0);
      n_total++; if (cur_code !== CW'(exp_seq[i]))
        $display("FAIL hold_resume%0d got %0d expected %0d", i, cur_code, exp_seq[i]); else n_pass++;
    end
    drive_cycle(0, 0, 0, 0);
    n_total++; if (settled !== 1'b1) $display("FAIL hold_lock got %b expected 1", settled); else n_pass++;
    drive_cycle(1, 60, 1, 0);
    n_total++; if (settled !== 1'b1 || cur_code !== 8'd20)
      $display("FAIL hold_no_accept got cur %0d settled %b expected cur 20 settled 1", cur_code, settled); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive_cycle(1, 28, 0, 0);
    drive_cycle(1, 5, 0, 0);
    n_total++; if (cur_code !== 8'd24 || code_ready !== 1'b0)
      $display("FAIL b2b_step1 got cur %0d ready %b expected 24 0", cur_code, code_ready); else n_pass++;
    drive_cycle(1, 5, 0, 0);
    n_total++; if (cur_code !== 8'd28 || code_ready !== 1'b0)
      $display("FAIL b2b_step2 got cur %0d ready %b expected 28 0", cur_code, code_ready); else n_pass++;
    drive_cycle(1, 5, 0, 0);
    n_total++; if (cur_code !== 8'd28 || settled !== 1'b1 || code_ready !== 1'b1)
      $display("FAIL b2b_lock got cur %0d settled %b ready %b expected 28 1 1", cur_code, settled, code_ready); else n_pass++;
    drive_cycle(1, 5, 0, 0);
    n_total++; if (settled !== 1'b0 || code_ready !== 1'b0)
      $display("FAIL b2b_accept got settled %b ready %b expected 0 0", settled, code_ready); else n_pass++;
    wait_settled(60);
    n_total++; if (cur_code !== 8'd5 || settled !== 1'b1)
      $display("FAIL b2b_final got cur %0d settled %b expected 5 1", cur_code, settled); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int max_seen = 0;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(1, 100, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0);
    drive_cycle(1, 90, 0, 1);
    n_total++; if (cur_code !== 8'd1 || settled !== 1'b0 || code_ready !== 1'b1 || coarse_out !== 128'h1)
      $display("FAIL rstmid_state got cur %0d settled %b ready %b coarse %h expected 1 0 1 1",
               cur_code, settled, code_ready, coarse_out); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(0, 0, 0, 0);
      if (int'(cur_code) > max_seen) max_seen = int'(cur_code);
    end
    n_total++; if (max_seen != 1 || settled !== 1'b0)
      $display("FAIL rstmid_abandon got max cur %0d settled %b expected 1 0", max_seen, settled); else n_pass++;
  endtask

  task automatic test_random();
    bit v, h, r;
    int code;
    drive_cycle(0, 0, 0, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom_range(0, 1) == 1);
      h = ($urandom_range(0, 99) < 15);
      r = ($urandom_range(0, 99) < 2);
      code = $urandom_range(0, 255);
      drive_cycle(v, code, h, r);
      n_total++; if (cur_code !== CW'(m_cur))
        $display("FAIL rnd_cur cyc %0d got %0d expected %0d", cyc, cur_code, m_cur); else n_pass++;
      n_total++; if (settled !== (m_phase == PH_LOCK))
        $display("FAIL rnd_settled cyc %0d got %b expected %b", cyc, settled, m_phase == PH_LOCK); else n_pass++;
      n_total++; if (code_ready !== (m_phase != PH_MOVE))
        $display("FAIL rnd_ready cyc %0d got %b expected %b", cyc, code_ready, m_phase != PH_MOVE); else n_pass++;
      n_total++; if (clamp_err !== m_clamp)
        $display("FAIL rnd_clamp cyc %0d got %b expected %b", cyc, clamp_err, m_clamp); else n_pass++;
      n_total++; if (coarse_out !== m_coarse)
        $display("FAIL rnd_coarse cyc %0d got %h expected %h", cyc, coarse_out, m_coarse); else n_pass++;
    end
  endtask

`ifdef DCO_CODE_DITHER_EN
  task automatic test_dither();
    int ones = 0;
    drive_cycle(0, 0, 0, 1);
    frac_in = 4'd4;
    drive_cycle(1, 50, 0, 0);
    frac_in = 4'd0;
    wait_settled(60);
    n_total++; if (settled !== 1'b1 || cur_code !== 8'd50)
      $display("FAIL dither_lock got cur %0d settled %b expected 50 1", cur_code, settled); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(0, 0, 0, 0);
      if (coarse_out[50] === 1'b1) ones++;
    end
    n_total++; if (ones != 4) $display("FAIL dither_ratio got %0d of 16 expected 4", ones); else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_slew();
    test_clamp();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DCO_CODE_DITHER_EN
    test_dither();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
